// File: rtl/binary2onehot_skid_if.sv
// Handshake bundle for binary2onehot_skid: binary index in, one-hot select out.
// The master side is the producer/consumer pair around the block; the slave side is the block.
interface binary2onehot_skid_if #(
  parameter int WIDTH = 4
);
  localparam int BIN_WIDTH = $clog2(WIDTH);

  logic                 in_valid;
  logic                 in_ready;
  logic [BIN_WIDTH-1:0] in_binary;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_one_hot;
  logic                 out_range_err;
  logic [7:0]           err_count;

  modport master (
    output in_valid,
    output in_binary,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_one_hot,
    input  out_range_err,
    input  err_count
  );

  modport slave (
    input  in_valid,
    input  in_binary,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_one_hot,
    output out_range_err,
    output err_count
  );
endinterface

// File: rtl/binary2onehot_skid.sv
// Registered binary-to-one-hot port-select decoder with a two-entry skid buffer.
// in_ready comes straight from the skid flop, so there is no combinational out_ready -> in_ready path.
module binary2onehot_skid #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  binary2onehot_skid_if.slave  bus
);
  localparam int                   BIN_WIDTH = $clog2(WIDTH);
  localparam logic [BIN_WIDTH:0]   WIDTH_EXT = (BIN_WIDTH + 1)'(WIDTH);

  logic [WIDTH-1:0] dec_one_hot;
  logic             dec_err;

  logic             main_valid;
  logic [WIDTH-1:0] main_one_hot;
  logic             main_err;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_one_hot;
  logic             skid_err;
  logic [7:0]       err_count;

  logic             accept;
  logic             emit;

  // Out-of-range indices decode to all zeros; the extra bit keeps the compare legal for any WIDTH.
  always_comb begin
    dec_one_hot = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dec_one_hot[i] = (bus.in_binary == BIN_WIDTH'(i));
    end
    dec_err = ({1'b0, bus.in_binary} >= WIDTH_EXT);
  end

  assign accept = bus.in_valid && !skid_valid;
  assign emit   = main_valid && bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid   <= 1'b0;
      main_one_hot <= '0;
      main_err     <= 1'b0;
      skid_valid   <= 1'b0;
      skid_one_hot <= '0;
      skid_err     <= 1'b0;
      err_count    <= 8'd0;
    end else begin
      if (accept && (!main_valid || emit)) begin
        main_valid   <= 1'b1;
        main_one_hot <= dec_one_hot;
        main_err     <= dec_err;
      end else if (accept) begin
        skid_valid   <= 1'b1;
        skid_one_hot <= dec_one_hot;
        skid_err     <= dec_err;
      end else if (emit && skid_valid) begin
        main_one_hot <= skid_one_hot;
        main_err     <= skid_err;
        skid_valid   <= 1'b0;
      end else if (emit) begin
        main_valid   <= 1'b0;
      end

      if (accept && dec_err && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  assign bus.in_ready      = !skid_valid;
  assign bus.out_valid     = main_valid;
  assign bus.out_one_hot   = main_one_hot;
  assign bus.out_range_err = main_err;
  assign bus.err_count     = err_count;
endmodule
